booth_mul_sched: RTL

- Iterative radix-2 Booth multiplier that two requesters share, with a sequencing FSM and round-robin arbitration.
- Accepts one signed operand pair at a time over valid/ready and runs one Booth step per clock.
- Returns the signed 2W-bit product over valid/ready, tagged with the requester ID.
- Sits between producer blocks and the downstream product consumer in the multiplier datapath.

---
 rtl/booth_mul_sched_if.sv | 35 +++
 rtl/booth_mul_sched.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/booth_mul_sched_if.sv
// Handshake bundle for booth_mul_sched: two operand request channels, one product channel
// and a busy status flag.
interface booth_mul_sched_if #(
    parameter int W = 4
);
    logic           req0_valid;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic           req0_ready;
    logic           req1_valid;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic           req1_ready;
    logic           res_valid;
    logic [2*W-1:0] res_p;
    logic           res_id;
    logic           res_ready;
    logic           busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_p, res_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_p, res_id, busy
    );
endinterface

// File: rtl/booth_mul_sched.sv
// Iterative radix-2 Booth multiplier shared by two round-robin requesters, one step per clock.
// Define BOOTH_MUL_SCHED_ZERO_BYPASS_EN to send zero-operand products straight to HOLD.
module booth_mul_sched #(
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_mul_sched_if.slave   io_bus
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LastStep = CW'(W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e         r_state, w_state_d;
    logic           r_rr_ptr, w_rr_ptr_d;
    logic [W:0]     r_m, w_m_d;
    logic [W:0]     r_a, w_a_d;
    logic [W-1:0]   r_q, w_q_d;
    logic           r_qm1, w_qm1_d;
    logic [CW-1:0]  r_cnt, w_cnt_d;
    logic           r_res_valid, w_res_valid_d;
    logic [2*W-1:0] r_res_p, w_res_p_d;
    logic           r_res_id, w_res_id_d;

    logic           w_gnt_id;
    logic           w_accept;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [W:0]     w_sum;
    logic [W:0]     w_a_sh;
    logic [W-1:0]   w_q_sh;

    // rr_ptr only matters when both requesters are valid; rst_n gates readies during reset.
    always_comb begin
        if (io_bus.req0_valid && io_bus.req1_valid) begin
            w_gnt_id = r_rr_ptr;
        end else begin
            w_gnt_id = io_bus.req1_valid;
        end
        w_accept = rst_n && (r_state == StIdle) && (io_bus.req0_valid || io_bus.req1_valid);
        w_sel_a  = w_gnt_id ? io_bus.req1_a : io_bus.req0_a;
        w_sel_b  = w_gnt_id ? io_bus.req1_b : io_bus.req0_b;
    end

    assign io_bus.req0_ready = w_accept & ~w_gnt_id;
    assign io_bus.req1_ready = w_accept & w_gnt_id;
    assign io_bus.res_valid  = r_res_valid;
    assign io_bus.res_p      = r_res_p;
    assign io_bus.res_id     = r_res_id;
    assign io_bus.busy       = (r_state != StIdle);

    // W+1-bit add/sub keeps M = -2^(W-1) exact; shift replicates A's sign.
    always_comb begin
        case ({r_q[0], r_qm1})
            2'b10:   w_sum = r_a - r_m;
            2'b01:   w_sum = r_a + r_m;
            default: w_sum = r_a;
        endcase
        w_a_sh = {w_sum[W], w_sum[W:1]};
        w_q_sh = {w_sum[0], r_q[W-1:1]};
    end

    always_comb begin
        w_state_d     = r_state;
        w_rr_ptr_d    = r_rr_ptr;
        w_m_d         = r_m;
        w_a_d         = r_a;
        w_q_d         = r_q;
        w_qm1_d       = r_qm1;
        w_cnt_d       = r_cnt;
        w_res_valid_d = r_res_valid;
        w_res_p_d     = r_res_p;
        w_res_id_d    = r_res_id;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_m_d      = {w_sel_a[W-1], w_sel_a};
                    w_q_d      = w_sel_b;
                    w_a_d      = '0;
                    w_qm1_d    = 1'b0;
                    w_cnt_d    = '0;
                    w_res_id_d = w_gnt_id;
                    w_rr_ptr_d = ~w_gnt_id;
                    w_state_d  = StRun;
`ifdef BOOTH_MUL_SCHED_ZERO_BYPASS_EN
                    if ((w_sel_a == '0) || (w_sel_b == '0)) begin
                        w_res_p_d     = '0;
                        w_res_valid_d = 1'b1;
                        w_state_d     = StHold;
                    end
`endif
                end
            end
            StRun: begin
                w_a_d   = w_a_sh;
                w_q_d   = w_q_sh;
                w_qm1_d = r_q[0];
                w_cnt_d = r_cnt + CW'(1);
                if (r_cnt == LastStep) begin
                    w_res_p_d     = {w_a_sh[W-1:0], w_q_sh};
                    w_res_valid_d = 1'b1;
                    w_state_d     = StHold;
                end
            end
            StHold: begin
                if (r_res_valid && io_bus.res_ready) begin
                    w_res_valid_d = 1'b0;
                    w_state_d     = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_rr_ptr    <= 1'b0;
            r_m         <= '0;
            r_a         <= '0;
            r_q         <= '0;
            r_qm1       <= 1'b0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_p     <= '0;
            r_res_id    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_rr_ptr    <= w_rr_ptr_d;
            r_m         <= w_m_d;
            r_a         <= w_a_d;
            r_q         <= w_q_d;
            r_qm1       <= w_qm1_d;
            r_cnt       <= w_cnt_d;
            r_res_valid <= w_res_valid_d;
            r_res_p     <= w_res_p_d;
            r_res_id    <= w_res_id_d;
        end
    end
endmodule
